// File: rtl/hc85_cascade_seq.sv
// Time-multiplexes one external 4-bit HC85 comparator over NIB nibbles, LSB nibble first.
// Latency: accept edge, then NIB RUN cycles, then a one-cycle DONE pulse. The next accept is possible one cycle later.
// Backpressure: START is sampled only in IDLE. A request made while busy is dropped and not queued.
// Optional feature macro: CMP_ONEHOT_CHECK_EN (sticky ERR on a non-one-hot comparator result).
module hc85_cascade_seq #(
    parameter int NIB  = 4,
    parameter int IDXW = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [4*NIB-1:0] opa_i,
    input  logic [4*NIB-1:0] opb_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             agb_o,
    output logic             asb_o,
    output logic             aeb_o,
    output logic             err_o,
    output logic [3:0]       cmp_a_o,
    output logic [3:0]       cmp_b_o,
    output logic             cmp_iagb_o,
    output logic             cmp_iasb_o,
    output logic             cmp_iaeb_o,
    input  logic             cmp_qagb_i,
    input  logic             cmp_qasb_i,
    input  logic             cmp_qaeb_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [4*NIB-1:0] opa_q;
    logic [4*NIB-1:0] opb_q;
    logic [2:0]       casc_q;     // {IAGB, IASB, IAEB} fed to the comparator
    logic [2:0]       res_q;      // final {AGB, ASB, AEB}
    logic             busy_q;
    logic             done_q;
    logic [2:0]       q_raw;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;

    assign q_raw = {cmp_qagb_i, cmp_qasb_i, cmp_qaeb_i};

    // Select the current nibble pair. idx_q and the operand copies freeze outside RUN, so CMP_A/B hold their last value.
    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
                nib_a = opa_q[4*i +: 4];
                nib_b = opb_q[4*i +: 4];
            end
        end
    end

    assign cmp_a_o    = nib_a;
    assign cmp_b_o    = nib_b;
    assign cmp_iagb_o = casc_q[2];
    assign cmp_iasb_o = casc_q[1];
    assign cmp_iaeb_o = casc_q[0];

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign agb_o  = res_q[2];
    assign asb_o  = res_q[1];
    assign aeb_o  = res_q[0];

    // Sequencer FSM.
    // On the last nibble, the comparator result goes to the result register only.
    // casc_q then keeps the cascade value that was in use, so the comparator inputs stay stable in DONE and IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            casc_q  <= 3'b001;
            res_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        opa_q   <= opa_i;
                        opb_q   <= opb_i;
                        idx_q   <= '0;
                        casc_q  <= 3'b001;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        res_q   <= q_raw;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        casc_q <= q_raw;
                        idx_q  <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CMP_ONEHOT_CHECK_EN
    logic err_q;
    logic err_d;

    // A comparator result is legal only when exactly one of the three bits is set.
    always_comb begin
        err_d = err_q;
        if (state_q == S_RUN &&
            !(q_raw == 3'b100 || q_raw == 3'b010 || q_raw == 3'b001)) begin
            err_d = 1'b1;
        end
    end

    // Sticky fault flag. Only reset clears it.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule
